song_recorder: RTL

//  Captures live key presses (one-hot note keys + octave select) as a song: encodes each press to
//  {octave, note, length} entries and writes them sequentially into an internal song RAM.

---
 rtl/song_recorder_if.sv | 19 +
 rtl/song_recorder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_recorder_if.sv
// Playback read port of the song recorder: the player drives the index, the recorder
// returns the {octave, note, length} entry plus the recording extent.
interface song_recorder_if #(
  parameter int OCTAVE_BITS = 2,
  parameter int NOTE_BITS   = 3,
  parameter int LENGTH_BITS = 3,
  parameter int ADDR_BITS   = 6
);
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [OCTAVE_BITS-1:0] rd_octave;
  logic [NOTE_BITS-1:0]   rd_note;
  logic [LENGTH_BITS-1:0] rd_length;
  logic [ADDR_BITS-1:0]   track;
  logic                   empty;
  logic                   full;

  modport master (output rd_addr, input rd_octave, rd_note, rd_length, track, empty, full);
  modport slave  (input rd_addr, output rd_octave, rd_note, rd_length, track, empty, full);
endinterface

// File: rtl/song_recorder.sv
// Records debounced one-hot key presses as {octave, note, length} entries into a song RAM.
// Optional feature macro REC_REST_EN: also records silences between notes as note=0 entries.
module song_recorder #(
  parameter int NOTE_KEY_BITS = 7,
  parameter int OCTAVE_BITS   = 2,
  parameter int NOTE_BITS     = 3,
  parameter int LENGTH_BITS   = 3,
  parameter int DEPTH         = 64,
  parameter int ADDR_BITS     = 6,
  parameter int UNIT_CYCLES   = 12_500_000,
  parameter int DEB_CYCLES    = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NOTE_KEY_BITS-1:0] key,
  input  logic [OCTAVE_BITS-1:0]   octave_in,
  song_recorder_if.slave           rd_bus,
  output logic                     recording,
  output logic [NOTE_KEY_BITS-1:0] led
);

  localparam int ENTRY_BITS = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;
  localparam int UNIT_W     = $clog2(UNIT_CYCLES + 1);
  localparam int DEB_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [UNIT_W-1:0]      UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [DEB_W-1:0]       DEB_FULL  = DEB_W'(DEB_CYCLES);
  localparam logic [LENGTH_BITS-1:0] LEN_MAX   = {LENGTH_BITS{1'b1}};
  localparam logic [LENGTH_BITS-1:0] LEN_ONE   = LENGTH_BITS'(1);
  localparam logic [NOTE_BITS-1:0]   NOTE_REST = {NOTE_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0]   LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_NOTE   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Lowest pressed key wins when several are held.
  function automatic logic [NOTE_BITS-1:0] encode_note(input logic [NOTE_KEY_BITS-1:0] k);
    logic [NOTE_BITS-1:0] n;
    n = NOTE_REST;
    for (int i = NOTE_KEY_BITS - 1; i >= 0; i--) begin
      n = k[i] ? NOTE_BITS'(i + 1) : n;
    end
    return n;
  endfunction

  logic [NOTE_KEY_BITS-1:0] cand_r, deb_key_r;
  logic [DEB_W-1:0]         deb_cnt_r, run_s;
  logic [NOTE_BITS-1:0]     deb_note_s, cur_note_r;
  logic [OCTAVE_BITS-1:0]   cur_oct_r;
  logic [UNIT_W-1:0]        unit_cnt_r, load_cnt_s;
  logic [LENGTH_BITS-1:0]   units_r, commit_len_s;
  logic [ADDR_BITS-1:0]     wr_ptr_r, track_r;
  logic                     empty_r, full_r, recording_r, en_q_r;
  logic                     en_rise_s, clear_s, load_s, wr_en_s, rd_valid_s;
  logic [ENTRY_BITS-1:0]    entry_s, rd_entry_r;
  logic [ENTRY_BITS-1:0]    mem_r [DEPTH];
  state_t                   state_r, state_nxt;

  // Length of the run of identical raw samples, including the current one.
  always_comb begin
    run_s = DEB_W'(1);
    if (key == cand_r) begin
      if (deb_cnt_r == DEB_FULL) begin
        run_s = DEB_FULL;
      end else begin
        run_s = deb_cnt_r + DEB_W'(1);
      end
    end else begin
      run_s = DEB_W'(1);
    end
  end

  // Debouncer: accept a key pattern only once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_r    <= {NOTE_KEY_BITS{1'b0}};
      deb_cnt_r <= {DEB_W{1'b0}};
      deb_key_r <= {NOTE_KEY_BITS{1'b0}};
    end else begin
      cand_r    <= key;
      deb_cnt_r <= run_s;
      if (run_s == DEB_FULL) deb_key_r <= key;
    end
  end

  assign deb_note_s = encode_note(deb_key_r);
  assign en_rise_s  = en & ~en_q_r;
  assign wr_en_s    = (state_r == ST_COMMIT) & ~rst;

  // Next-state logic; a note entered via COMMIT starts its unit count at 1 to cover the commit cycle.
  always_comb begin
    state_nxt  = state_r;
    clear_s    = 1'b0;
    load_s     = 1'b0;
    load_cnt_s = {UNIT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (en_rise_s) begin
          state_nxt = ST_ARM;
          clear_s   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (deb_note_s != NOTE_REST) begin
          state_nxt = ST_NOTE;
          load_s    = 1'b1;
        end else begin
          state_nxt = ST_ARM;
        end
      end
      ST_NOTE: begin
        if (!en && (cur_note_r == NOTE_REST)) begin
          state_nxt = ST_IDLE;
        end else if (!en || (deb_note_s != cur_note_r)) begin
          state_nxt = ST_COMMIT;
        end else begin
          state_nxt = ST_NOTE;
        end
      end
      ST_COMMIT: begin
        if (wr_ptr_r == LAST_ADDR) begin
          state_nxt = ST_DONE;
        end else if (!en) begin
          state_nxt = ST_IDLE;
        end else if (deb_note_s != NOTE_REST) begin
          state_nxt  = ST_NOTE;
          load_s     = 1'b1;
          load_cnt_s = UNIT_W'(1);
        end else begin
`ifdef REC_REST_EN
          state_nxt  = ST_NOTE;
          load_s     = 1'b1;
          load_cnt_s = UNIT_W'(1);
`else
          state_nxt  = ST_ARM;
`endif
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Committed length is at least one unit.
  always_comb begin
    if (units_r == {LENGTH_BITS{1'b0}}) begin
      commit_len_s = LEN_ONE;
    end else begin
      commit_len_s = units_r;
    end
  end

  assign entry_s = {cur_oct_r, cur_note_r, commit_len_s};

  // FSM state, write pointer, recording extent and note timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      en_q_r      <= 1'b0;
      recording_r <= 1'b0;
      wr_ptr_r    <= {ADDR_BITS{1'b0}};
      track_r     <= {ADDR_BITS{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      cur_note_r  <= NOTE_REST;
      cur_oct_r   <= {OCTAVE_BITS{1'b0}};
      unit_cnt_r  <= {UNIT_W{1'b0}};
      units_r     <= {LENGTH_BITS{1'b0}};
    end else begin
      state_r     <= state_nxt;
      en_q_r      <= en;
      recording_r <= (state_nxt == ST_ARM) || (state_nxt == ST_NOTE) || (state_nxt == ST_COMMIT);
      if (clear_s) begin
        wr_ptr_r <= {ADDR_BITS{1'b0}};
        track_r  <= {ADDR_BITS{1'b0}};
        empty_r  <= 1'b1;
        full_r   <= 1'b0;
      end else if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_BITS'(1);
        track_r  <= wr_ptr_r;
        empty_r  <= 1'b0;
        if (wr_ptr_r == LAST_ADDR) full_r <= 1'b1;
      end
      if (load_s) begin
        cur_note_r <= deb_note_s;
        cur_oct_r  <= (deb_note_s == NOTE_REST) ? {OCTAVE_BITS{1'b0}} : octave_in;
        unit_cnt_r <= load_cnt_s;
        units_r    <= {LENGTH_BITS{1'b0}};
      end else if (state_r == ST_NOTE) begin
        if (unit_cnt_r == UNIT_LAST) begin
          unit_cnt_r <= {UNIT_W{1'b0}};
          if (units_r != LEN_MAX) units_r <= units_r + LEN_ONE;
        end else begin
          unit_cnt_r <= unit_cnt_r + UNIT_W'(1);
        end
      end
    end
  end

  // Song RAM write port; contents survive reset, validity comes from empty/track.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= entry_s;
  end

  assign rd_valid_s = ~empty_r && (rd_bus.rd_addr <= track_r);

  // Read-first registered read port; out-of-range or empty reads return a rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_entry_r <= {ENTRY_BITS{1'b0}};
    end else if (rd_valid_s) begin
      rd_entry_r <= mem_r[rd_bus.rd_addr];
    end else begin
      rd_entry_r <= {ENTRY_BITS{1'b0}};
    end
  end

  assign {rd_bus.rd_octave, rd_bus.rd_note, rd_bus.rd_length} = rd_entry_r;
  assign rd_bus.track = track_r;
  assign rd_bus.empty = empty_r;
  assign rd_bus.full  = full_r;
  assign recording    = recording_r;
  assign led          = deb_key_r;

endmodule
